// File: rtl/sprite_pkg.sv
// Shared sizes, FSM state encoding and record layouts for the sprite line engine.
// Sprite table entries are stored as written; line slots hold the per-line view
// (index, x, row within sprite, attribute bits) for the pixel matcher.
package sprite_pkg;
   localparam int NUM_SPR  = 64;
   localparam int IDX_W    = 6;
   localparam int MAX_LINE = 8;
   localparam int SLOT_W   = 3;
   localparam int CNT_W    = 4;
   localparam int SPR_SZ   = 16;
   localparam int RC_W     = 4;
   localparam int X_W      = 10;
   localparam int Y_W      = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_SWAP = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic            vis;
      logic [X_W-1:0]  x;
      logic [Y_W-1:0]  y;
      logic            attr;
      logic            pos;
   } spr_entry_t;

   typedef struct packed {
      logic [IDX_W-1:0] id;
      logic [X_W-1:0]   x;
      logic [RC_W-1:0]  row;
      logic             attr;
      logic             pos;
   } slot_t;
endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute table: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after wr_en; read is same-cycle (returns old data on a colliding write).
// Backpressure: none, every write is accepted.
module sprite_attr_table
   import sprite_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_sel,
   input  spr_entry_t       wr_dat,
   input  logic [IDX_W-1:0] rd_idx,
   output spr_entry_t       rd_dat
);
   spr_entry_t mem [NUM_SPR];

   // Table storage; reset clears every entry so nothing is visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SPR; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_sel] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_idx];
endmodule

// File: rtl/sprite_line_engine.sv
// Sprite line engine: scans the table in hblank into back slots, swaps to front, matches pixels.
// Latency: scan NUM_SPR+1 cycles per line; pixel lookup registered, 1 cycle after pix_valid.
// Backpressure: none; a line_start during a scan aborts it and restarts with the new line.
module sprite_line_engine
   import sprite_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_sel,
   input  logic [X_W-1:0]   wr_x,
   input  logic [Y_W-1:0]   wr_y,
   input  logic             wr_vis,
   input  logic             wr_attr,
   input  logic             wr_pos,
   input  logic             line_start,
   input  logic [Y_W-1:0]   next_line,
   input  logic             pix_valid,
   input  logic [X_W-1:0]   pix_x,
   output logic             hit,
   output logic [IDX_W-1:0] hit_id,
   output logic [RC_W-1:0]  hit_row,
   output logic [RC_W-1:0]  hit_col,
   output logic             hit_attr,
   output logic             hit_behind,
   output logic             overflow,
   output logic             scan_busy
);
   scan_state_t      state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [Y_W-1:0]   cur_line;
   logic [CNT_W-1:0] back_cnt, front_cnt;
   logic             ovf_back;
   slot_t            back_slot  [MAX_LINE];
   slot_t            front_slot [MAX_LINE];
   spr_entry_t       wr_ent, rd_ent;
   logic             qualify;
   logic [RC_W-1:0]  row;
   logic             found;
   slot_t            win;
   logic [RC_W-1:0]  col;

   assign wr_ent = '{vis: wr_vis, x: wr_x, y: wr_y, attr: wr_attr, pos: wr_pos};

   sprite_attr_table u_table (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_sel (wr_sel),
      .wr_dat (wr_ent),
      .rd_idx (idx),
      .rd_dat (rd_ent)
   );

   // Vertical qualification in 10 bits so sprites near the bottom never wrap to line 0.
   assign qualify = rd_ent.vis &&
                    ({1'b0, cur_line} >= {1'b0, rd_ent.y}) &&
                    ({1'b0, cur_line} <  ({1'b0, rd_ent.y} + 10'(SPR_SZ)));
   assign row = cur_line[RC_W-1:0] - rd_ent.y[RC_W-1:0];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state: line_start (re)starts a scan from any state; last index hands over to SWAP.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (line_start) state_nxt = ST_SCAN;
         ST_SCAN: begin
            if (line_start)                          state_nxt = ST_SCAN;
            else if (idx == IDX_W'(NUM_SPR - 1))     state_nxt = ST_SWAP;
         end
         ST_SWAP: state_nxt = line_start ? ST_SCAN : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Scan datapath: fill back slots in index order, then publish them to the front on SWAP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         cur_line  <= '0;
         back_cnt  <= '0;
         front_cnt <= '0;
         ovf_back  <= 1'b0;
         overflow  <= 1'b0;
         for (int s = 0; s < MAX_LINE; s++) begin
            back_slot[s]  <= '0;
            front_slot[s] <= '0;
         end
      end else begin
         if (line_start) begin
            cur_line <= next_line;
            idx      <= '0;
            back_cnt <= '0;
            ovf_back <= 1'b0;
         end else if (state == ST_SCAN) begin
            if (qualify) begin
               if (back_cnt < CNT_W'(MAX_LINE)) begin
                  back_slot[back_cnt[SLOT_W-1:0]] <= '{id: idx, x: rd_ent.x, row: row,
                                                       attr: rd_ent.attr, pos: rd_ent.pos};
                  back_cnt <= back_cnt + 1'b1;
               end else begin
                  ovf_back <= 1'b1;
               end
            end
            idx <= idx + 1'b1;
         end
         if (state == ST_SWAP) begin
            for (int s = 0; s < MAX_LINE; s++) front_slot[s] <= back_slot[s];
            front_cnt <= back_cnt;
            overflow  <= ovf_back;
         end
      end
   end

   // Priority matcher: lowest occupied slot covering pix_x wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int s = MAX_LINE - 1; s >= 0; s--) begin
         if ((CNT_W'(s) < front_cnt) &&
             ({1'b0, pix_x} >= {1'b0, front_slot[s].x}) &&
             ({1'b0, pix_x} <  ({1'b0, front_slot[s].x} + 11'(SPR_SZ)))) begin
            found = 1'b1;
            win   = front_slot[s];
         end
      end
      col = pix_x[RC_W-1:0] - win.x[RC_W-1:0];
   end

   // Registered pixel result; everything zero when idle or uncovered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit        <= 1'b0;
         hit_id     <= '0;
         hit_row    <= '0;
         hit_col    <= '0;
         hit_attr   <= 1'b0;
         hit_behind <= 1'b0;
      end else if (pix_valid && found) begin
         hit        <= 1'b1;
         hit_id     <= win.id;
         hit_row    <= win.row;
         hit_col    <= col;
         hit_attr   <= win.attr;
         hit_behind <= win.pos;
      end else begin
         hit        <= 1'b0;
         hit_id     <= '0;
         hit_row    <= '0;
         hit_col    <= '0;
         hit_attr   <= 1'b0;
         hit_behind <= 1'b0;
      end
   end

   assign scan_busy = (state != ST_IDLE);
endmodule
